// File: rtl/gain_ramp_pkg.sv
// gain_ramp_pkg: sequencer state encoding and gain constants shared by the gain_ramp block
package gain_ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL_L = 2'd1,
        ST_MUL_R = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int GW_DEFAULT = 16;
    localparam logic [GW_DEFAULT-1:0] UNITY_GAIN = GW_DEFAULT'(1) << (GW_DEFAULT - 1);

    function automatic int unsigned unity_gain(input int unsigned gw);
        return 32'd1 << (gw - 1);
    endfunction

endpackage

// File: rtl/gain_ramp_if.sv
// gain_ramp_if: stereo sample strobe in, scaled stereo result out
interface gain_ramp_if
    import gain_ramp_pkg::*;
#(
    parameter int DW = 16,
    parameter int GW = GW_DEFAULT
);
    logic                 ena;
    logic signed [DW-1:0] in_l;
    logic signed [DW-1:0] in_r;
    logic [GW-1:0]        gain_tgt;
    logic                 mute;
    logic                 busy;
    logic signed [DW+1:0] out_l;
    logic signed [DW+1:0] out_r;
    logic                 valid;

    modport master (
        output ena, in_l, in_r, gain_tgt, mute,
        input  busy, out_l, out_r, valid
    );

    modport slave (
        input  ena, in_l, in_r, gain_tgt, mute,
        output busy, out_l, out_r, valid
    );
endinterface

// File: rtl/gain_slew.sv
// gain_slew: applied gain register that moves toward a target by at most RSTEP per step strobe
module gain_slew
    import gain_ramp_pkg::*;
#(
    parameter int            GW    = GW_DEFAULT,
    parameter logic [GW-1:0] RSTEP = GW'(64)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step_i,
    input  logic [GW-1:0] tgt_i,
    output logic [GW-1:0] cur_o
);
    logic [GW-1:0] cur_q, cur_d, up, dn;

    // distances are only taken in the direction that is actually non-negative, so nothing wraps
    always_comb begin
        up    = tgt_i - cur_q;
        dn    = cur_q - tgt_i;
        cur_d = !step_i           ? cur_q :
                (cur_q < tgt_i)   ? cur_q + ((up < RSTEP) ? up : RSTEP) :
                (cur_q > tgt_i)   ? cur_q - ((dn < RSTEP) ? dn : RSTEP) :
                                    cur_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cur_q <= '0;
        else
            cur_q <= cur_d;
    end

    assign cur_o = cur_q;
endmodule

// File: rtl/gain_ramp.sv
// gain_ramp: stereo gain stage with slewed gain, one multiplier shared between left and right
module gain_ramp
    import gain_ramp_pkg::*;
#(
    parameter int            DW    = 16,
    parameter int            GW    = GW_DEFAULT,
    parameter logic [GW-1:0] RSTEP = GW'(64)
) (
    input  logic        clk,
    input  logic        reset_n,
    gain_ramp_if.slave  bus
);
    state_e               state_q, state_d;
    logic                 accept, valid_q;
    logic [GW-1:0]        tgt, cur_gain;
    logic signed [DW-1:0] inl_q, inr_q, mul_a;
    logic signed [DW+GW:0] a_x, g_x, mul_p, prod_q;
    logic signed [DW+1:0] hold_q, outl_q, outr_q;
    logic                 unused_bits;

    always_comb begin
        accept  = (state_q == ST_IDLE) && bus.ena;
        state_d = (state_q == ST_IDLE)  ? (bus.ena ? ST_MUL_L : ST_IDLE) :
                  (state_q == ST_MUL_L) ? ST_MUL_R :
                  (state_q == ST_MUL_R) ? ST_DONE  :
                                          ST_IDLE;
    end

    assign tgt = bus.mute ? '0 : bus.gain_tgt;

    gain_slew #(.GW(GW), .RSTEP(RSTEP)) u_slew (
        .clk     (clk),
        .reset_n (reset_n),
        .step_i  (accept),
        .tgt_i   (tgt),
        .cur_o   (cur_gain)
    );

    // gain is zero-extended so the multiply stays signed with an unsigned Q1.(GW-1) factor
    assign mul_a = (state_q == ST_MUL_L) ? inl_q : inr_q;
    assign a_x   = {{(GW+1){mul_a[DW-1]}}, mul_a};
    assign g_x   = {{(DW+1){1'b0}}, cur_gain};
    assign mul_p = a_x * g_x;

    // slicing from bit GW-1 is the arithmetic shift by GW-1, floor toward -inf
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            inl_q   <= '0;
            inr_q   <= '0;
            prod_q  <= '0;
            hold_q  <= '0;
            outl_q  <= '0;
            outr_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= state_q == ST_DONE;
            if (accept) begin
                inl_q <= bus.in_l;
                inr_q <= bus.in_r;
            end
            if (state_q == ST_MUL_L || state_q == ST_MUL_R)
                prod_q <= mul_p;
            if (state_q == ST_MUL_R)
                hold_q <= prod_q[GW-1 +: DW+2];
            if (state_q == ST_DONE) begin
                outl_q <= hold_q;
                outr_q <= prod_q[GW-1 +: DW+2];
            end
        end
    end

    assign unused_bits = ^{mul_p[GW-2:0], prod_q[GW-2:0]};

    assign bus.busy  = state_q != ST_IDLE;
    assign bus.valid = valid_q;
    assign bus.out_l = outl_q;
    assign bus.out_r = outr_q;
endmodule

// File: tb/tb_gain_ramp.sv
// tb_gain_ramp: directed stimulus with a scoreboard of expected stereo results and latencies
module tb_gain_ramp;
    localparam int DW = 16;
    localparam int GW = 16;

    typedef struct {
        longint l;
        longint r;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passes = 0;
    int   total = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   g = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gain_ramp_if #(.DW(DW), .GW(GW)) bus ();

    gain_ramp #(.DW(DW), .GW(GW), .RSTEP(16'd64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint scale(input longint x, input longint gg);
        return (x * gg) >>> (GW - 1);
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (cur < tgt) return (tgt - cur < 64) ? tgt : cur + 64;
        if (cur > tgt) return (cur - tgt < 64) ? tgt : cur - 64;
        return cur;
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.valid === 1'b1) begin
            nvalid++;
            if (q.size() == 0) begin
                chk("spurious_valid", q.size(), 1);
            end else begin
                mon_e = q.pop_front();
                chk("out_l", bus.out_l, mon_e.l);
                chk("out_r", bus.out_r, mon_e.r);
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    // caller is always at a falling edge; returns one falling edge after the strobe
    task automatic send(input int l, input int r, input int tgt, input logic m);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", bus.busy, 0);
        bus.ena      = 1'b1;
        bus.in_l     = 16'(l);
        bus.in_r     = 16'(r);
        bus.gain_tgt = 16'(tgt);
        bus.mute     = m;
        g = ramp(g, m ? 0 : tgt);
        q.push_back('{scale(l, g), scale(r, g), cyc + 4});
        @(negedge clk);
        bus.ena = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int n;
        int nv;
        int acc;
        bus.ena = 1'b0;
        bus.in_l = '0;
        bus.in_r = '0;
        bus.gain_tgt = '0;
        bus.mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_out_l", bus.out_l, 0);
        chk("rst_out_r", bus.out_r, 0);
        chk("rst_gain", dut.u_slew.cur_q, 0);
        reset_n = 1'b1;
        @(negedge clk);

        send(16'h4000, -16'sh4000, 16'h8000, 1'b0);
        chk("first_gain", dut.u_slew.cur_q, 16'h0040);
        chk("first_busy", bus.busy, 1);
        drain();

        for (int i = 1; i < 512; i++) send(i, -i, 16'h8000, 1'b0);
        drain();
        chk("ramp_unity", dut.u_slew.cur_q, 16'h8000);
        for (int i = 0; i < 4; i++) send(i * 3, i, 16'h8000, 1'b0);
        drain();
        chk("hold_unity", dut.u_slew.cur_q, 16'h8000);
        send(1000, -1000, 16'h8000, 1'b0);
        drain();

        for (int i = 0; i < 520; i++) send(i * 37, -i * 37, 16'hFFFF, 1'b0);
        drain();
        chk("ramp_full", dut.u_slew.cur_q, 16'hFFFF);
        send(-32768, 32767, 16'hFFFF, 1'b0);
        drain();

        n = 0;
        while (g != 16'h4000 && n < 1000) begin
            send(7, -7, 16'h4000, 1'b0);
            n++;
        end
        drain();
        chk("ramp_down", dut.u_slew.cur_q, 16'h4000);
        send(-1, 1, 16'h4000, 1'b0);
        drain();

        nv = nvalid;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            bus.ena      = 1'b1;
            bus.in_l     = 16'(i * 100 + 1);
            bus.in_r     = 16'(-i * 50 - 3);
            bus.gain_tgt = 16'h8000;
            bus.mute     = 1'b0;
            if (bus.busy === 1'b0) begin
                acc++;
                g = ramp(g, 16'h8000);
                q.push_back('{scale(i * 100 + 1, g), scale(-i * 50 - 3, g), cyc + 4});
            end
            @(negedge clk);
        end
        bus.ena = 1'b0;
        drain();
        chk("b2b_valids", nvalid - nv, 3);
        chk("b2b_accepts", acc, 3);
        chk("b2b_gain", dut.u_slew.cur_q, 16'h40C0);

        n = 0;
        while (g != 16'h8000 && n < 400) begin
            send(n, -n, 16'h8000, 1'b0);
            n++;
        end
        drain();
        chk("mute_start", dut.u_slew.cur_q, 16'h8000);
        for (int k = 1; k <= 3; k++) begin
            send(500, -500, 16'h8000, 1'b1);
            drain();
            chk("mute_ramp", dut.u_slew.cur_q, 16'h8000 - k * 16'h40);
        end

        send(1234, -1234, 16'h8000, 1'b1);
        @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", bus.valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_l", bus.out_l, 0);
        chk("abort_out_r", bus.out_r, 0);
        chk("abort_gain", dut.u_slew.cur_q, 0);
        q.delete();
        g = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nv = nvalid;
        repeat (8) @(negedge clk);
        chk("no_valid_abort", nvalid - nv, 0);

        send(100, -100, 16'h8000, 1'b1);
        drain();
        chk("mute_at_zero", dut.u_slew.cur_q, 0);

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
